// File: rtl/lut_mult_accum.sv
// Accumulates ACC_LEN signed 16-bit products into an ACC_W-bit sum and emits it over valid/ready.
// Define LUT_MULT_ACCUM_SKID_EN to keep accumulating the next batch while a finished sum waits.
`timescale 1ns/1ps
module lut_mult_accum #(
    parameter int ACC_LEN = 8,
    parameter int ACC_W   = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic [15:0]      prod_i,
    input  logic             prod_valid_i,
    output logic             prod_ready_o,
    output logic [ACC_W-1:0] sum_o,
    output logic             sum_valid_o,
    input  logic             sum_ready_i,
    output logic             ovf_o,
    output logic [7:0]       cnt_o
);
    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam logic [7:0] LAST_CNT = 8'(ACC_LEN - 1);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             ovf_q, ovf_d;
    logic             sum_valid_q, sum_valid_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] add_res;
    logic             add_ovf;
    logic             is_last;
    logic             prod_accept;
    logic             sum_accept;

    always_comb begin
        prod_ext   = {{(ACC_W-16){prod_i[15]}}, prod_i};
        add_res    = acc_q + prod_ext;
        // Signed overflow: operands agree in sign but the wrapped result does not.
        add_ovf    = (acc_q[ACC_W-1] == prod_i[15]) && (add_res[ACC_W-1] != acc_q[ACC_W-1]);
        is_last    = (cnt_q == LAST_CNT);
        sum_accept = sum_valid_q && sum_ready_i;
`ifdef LUT_MULT_ACCUM_SKID_EN
        // In HOLD only the closing product must wait, unless the held sum leaves this cycle.
        prod_ready_o = !clear_i && ((state_q == ACCUM) || !is_last || sum_ready_i);
`else
        prod_ready_o = !clear_i && (state_q == ACCUM);
`endif
        prod_accept = prod_valid_i && prod_ready_o;
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no branch can leave a latch behind.
        state_d     = state_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        flag_d      = flag_q;
        ovf_d       = ovf_q;
        sum_valid_d = sum_valid_q;

        if ((state_q == HOLD) && sum_accept) begin
            sum_valid_d = 1'b0;
            state_d     = ACCUM;
        end

        // Evaluated after the output release so a same-cycle closing product re-arms sum_valid.
        if (clear_i) begin
            acc_d  = '0;
            cnt_d  = '0;
            flag_d = 1'b0;
        end else if (prod_accept) begin
            if (is_last) begin
                sum_d       = add_res;
                ovf_d       = flag_q | add_ovf;
                sum_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                flag_d      = 1'b0;
                state_d     = HOLD;
            end else begin
                acc_d  = add_res;
                cnt_d  = cnt_q + 8'd1;
                flag_d = flag_q | add_ovf;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            flag_q      <= 1'b0;
            ovf_q       <= 1'b0;
            sum_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            flag_q      <= flag_d;
            ovf_q       <= ovf_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign sum_o       = sum_q;
    assign sum_valid_o = sum_valid_q;
    assign ovf_o       = ovf_q;
    assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_lut_mult_accum.sv
// Self-checking bench for lut_mult_accum: three instances (8x24, 4x17, 2x24) checked every cycle
// against a batch-level reference model, plus a vector table and directed corner sequences.
`timescale 1ns/1ps
module tb_lut_mult_accum;
`ifdef LUT_MULT_ACCUM_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int LEN [3] = '{8, 4, 2};
    localparam int WID [3] = '{24, 17, 24};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  clr, vld, srdy, rdy, svld, ovf;
    logic [15:0] prod [3];
    logic [7:0]  cnt [3];
    logic [23:0] sum0;
    logic [16:0] sum1;
    logic [23:0] sum2;

    always #5 clk = ~clk;

    lut_mult_accum #(.ACC_LEN(8), .ACC_W(24)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clear_i(clr[0]), .prod_i(prod[0]), .prod_valid_i(vld[0]),
        .prod_ready_o(rdy[0]), .sum_o(sum0), .sum_valid_o(svld[0]), .sum_ready_i(srdy[0]),
        .ovf_o(ovf[0]), .cnt_o(cnt[0]));
    lut_mult_accum #(.ACC_LEN(4), .ACC_W(17)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear_i(clr[1]), .prod_i(prod[1]), .prod_valid_i(vld[1]),
        .prod_ready_o(rdy[1]), .sum_o(sum1), .sum_valid_o(svld[1]), .sum_ready_i(srdy[1]),
        .ovf_o(ovf[1]), .cnt_o(cnt[1]));
    lut_mult_accum #(.ACC_LEN(2), .ACC_W(24)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clear_i(clr[2]), .prod_i(prod[2]), .prod_valid_i(vld[2]),
        .prod_ready_o(rdy[2]), .sum_o(sum2), .sum_valid_o(svld[2]), .sum_ready_i(srdy[2]),
        .ovf_o(ovf[2]), .cnt_o(cnt[2]));

    int total = 0;
    int bad   = 0;
    int cyc_cnt = 0;

    // Reference model: held result plus the list of products accepted into the open batch.
    bit     m_hold [3];
    longint m_sum  [3];
    bit     m_ovf  [3];
    longint m_batch [3][$];
    longint seen2 [$];

    typedef struct {
        bit          vld;
        logic [15:0] prod;
        bit          srdy;
        bit          e_rdy;
        bit          e_sv;
        longint      e_sum;
        bit          e_ovf;
        int          e_cnt;
    } vec_t;
    vec_t tbl [$];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [63:0] get_sum(input int i);
        logic signed [63:0] r;
        case (i)
            0:       r = $signed(sum0);
            1:       r = $signed(sum1);
            default: r = $signed(sum2);
        endcase
        return r;
    endfunction

    function automatic bit m_ready(input int i);
        if (clr[i]) return 1'b0;
        if (!m_hold[i]) return 1'b1;
        if (!SKID) return 1'b0;
        return (m_batch[i].size() != LEN[i] - 1) || srdy[i];
    endfunction

    // Sum the batch in wide arithmetic; any partial sum outside the ACC_W signed range wraps and flags.
    function automatic void close_batch(input int i);
        longint lim = longint'(1) << (WID[i] - 1);
        longint a = 0;
        bit     o = 1'b0;
        for (int n = 0; n < m_batch[i].size(); n++) begin
            a += m_batch[i][n];
            if (a >= lim) begin a -= 2 * lim; o = 1'b1; end
            else if (a < -lim) begin a += 2 * lim; o = 1'b1; end
        end
        m_sum[i] = a;
        m_ovf[i] = o;
        m_hold[i] = 1'b1;
        m_batch[i].delete();
    endfunction

    function automatic void m_step(input int i, input bit r);
        if (!rst_n) begin
            m_hold[i] = 1'b0; m_sum[i] = 0; m_ovf[i] = 1'b0;
            m_batch[i].delete();
            return;
        end
        if (m_hold[i] && srdy[i]) m_hold[i] = 1'b0;
        if (clr[i]) begin
            m_batch[i].delete();
        end else if (vld[i] && r) begin
            m_batch[i].push_back(longint'($signed(prod[i])));
            if (m_batch[i].size() == LEN[i]) close_batch(i);
        end
    endfunction

    task automatic drive(input int i, input bit c, input bit v, input logic [15:0] p, input bit s);
        for (int j = 0; j < 3; j++) begin
            clr[j] = 1'b0; vld[j] = 1'b0; prod[j] = 16'h0; srdy[j] = 1'b1;
        end
        clr[i] = c; vld[i] = v; prod[i] = p; srdy[i] = s;
    endtask

    // Called at the falling edge: compare every instance to the model, advance the model, cross the edge.
    task automatic tick();
        bit r [3];
        for (int i = 0; i < 3; i++) begin
            r[i] = m_ready(i);
            check($sformatf("d%0d_ready", i), rdy[i], r[i]);
            check($sformatf("d%0d_cnt", i), cnt[i], m_batch[i].size());
            check($sformatf("d%0d_svalid", i), svld[i], m_hold[i]);
            check($sformatf("d%0d_sum", i), get_sum(i), m_sum[i]);
            check($sformatf("d%0d_ovf", i), ovf[i], m_ovf[i]);
        end
        if (svld[2]) seen2.push_back(get_sum(2));
        for (int i = 0; i < 3; i++) m_step(i, r[i]);
        cyc_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input int i, input bit c, input bit v, input logic [15:0] p, input bit s);
        drive(i, c, v, p, s);
        @(negedge clk);
        tick();
    endtask

    task automatic push(input int i, input logic [15:0] p, input bit s);
        bit got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            drive(i, 1'b0, 1'b1, p, s);
            @(negedge clk);
            got = rdy[i];
            tick();
        end
        check($sformatf("d%0d_push_accepted", i), got, 1'b1);
    endtask

    task automatic add_row(input bit v, input logic [15:0] p, input bit s, input bit er,
                           input bit esv, input longint esum, input bit eovf, input int ecnt);
        vec_t row;
        row.vld = v; row.prod = p; row.srdy = s; row.e_rdy = er;
        row.e_sv = esv; row.e_sum = esum; row.e_ovf = eovf; row.e_cnt = ecnt;
        tbl.push_back(row);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n0;

        // Vectors for instance 0 (ACC_LEN=8, ACC_W=24), all with sum_ready_i=1.
        for (int j = 0; j < 8; j++) add_row(1, 16'(2 * (j + 1)), 1, 1, 0, 0, 0, j);
        add_row(0, 16'h0, 1, SKID, 1, 72, 0, 0);
        add_row(0, 16'h0, 1, 1, 0, 0, 0, 0);
        for (int j = 0; j < 4; j++) add_row(1, 16'hFFFE, 1, 1, 0, 0, 0, j);
        for (int j = 4; j < 8; j++) add_row(1, 16'h0003, 1, 1, 0, 0, 0, j);
        add_row(0, 16'h0, 1, SKID, 1, 4, 0, 0);
        add_row(0, 16'h0, 1, 1, 0, 0, 0, 0);
        for (int j = 0; j < 8; j++) add_row(1, 16'hFF00, 1, 1, 0, 0, 0, j);
        add_row(0, 16'h0, 1, SKID, 1, -2048, 0, 0);
        add_row(0, 16'h0, 1, 1, 0, 0, 0, 0);

        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        tick();
        rst_n = 1'b1;

        foreach (tbl[n]) begin
            drive(0, 1'b0, tbl[n].vld, tbl[n].prod, tbl[n].srdy);
            @(negedge clk);
            check($sformatf("tbl%0d_ready", n), rdy[0], tbl[n].e_rdy);
            check($sformatf("tbl%0d_cnt", n), cnt[0], tbl[n].e_cnt);
            check($sformatf("tbl%0d_svalid", n), svld[0], tbl[n].e_sv);
            if (tbl[n].e_sv) begin
                check($sformatf("tbl%0d_sum", n), get_sum(0), tbl[n].e_sum);
                check($sformatf("tbl%0d_ovf", n), ovf[0], tbl[n].e_ovf);
            end
            tick();
        end

        // Backpressure: finished sum held for 5 cycles, then released.
        for (int j = 0; j < 8; j++) cycle(0, 1'b0, 1'b1, 16'd1, 1'b0);
        for (int j = 0; j < 5; j++) begin
            drive(0, 1'b0, 1'b1, 16'd1, 1'b0);
            @(negedge clk);
            check("bp_ready", rdy[0], SKID);
            check("bp_sum", get_sum(0), 8);
            check("bp_svalid", svld[0], 1);
            tick();
        end
        cycle(0, 1'b0, 1'b0, 16'h0, 1'b1);
        drive(0, 1'b0, 1'b1, 16'd1, 1'b1);
        @(negedge clk);
        check("bp_release_ready", rdy[0], 1);
        check("bp_release_svalid", svld[0], 0);
        tick();
        cycle(0, 1'b1, 1'b0, 16'h0, 1'b1);

        // Overflow on the 17-bit instance, then a clean batch.
        for (int j = 0; j < 4; j++) cycle(1, 1'b0, 1'b1, 16'h7FFF, 1'b1);
        drive(1, 1'b0, 1'b0, 16'h0, 1'b1);
        @(negedge clk);
        check("ovf_flag", ovf[1], 1);
        check("ovf_sum", get_sum(1), -4);
        tick();
        for (int j = 0; j < 4; j++) cycle(1, 1'b0, 1'b1, 16'h0001, 1'b1);
        drive(1, 1'b0, 1'b0, 16'h0, 1'b1);
        @(negedge clk);
        check("ovf_next_flag", ovf[1], 0);
        check("ovf_next_sum", get_sum(1), 4);
        tick();

        // Clear mid-batch, with a product offered in the same cycle.
        for (int j = 0; j < 3; j++) cycle(0, 1'b0, 1'b1, 16'd5, 1'b1);
        drive(0, 1'b1, 1'b1, 16'd5, 1'b1);
        @(negedge clk);
        check("clr_ready", rdy[0], 0);
        tick();
        drive(0, 1'b0, 1'b1, 16'd1, 1'b1);
        @(negedge clk);
        check("clr_cnt", cnt[0], 0);
        tick();
        for (int j = 0; j < 7; j++) cycle(0, 1'b0, 1'b1, 16'd1, 1'b1);
        drive(0, 1'b0, 1'b0, 16'h0, 1'b1);
        @(negedge clk);
        check("clr_sum", get_sum(0), 8);
        tick();

        // Clear while a sum is held leaves it; clear plus handshake both apply.
        for (int j = 0; j < 8; j++) cycle(0, 1'b0, 1'b1, 16'd2, 1'b0);
        cycle(0, 1'b1, 1'b0, 16'h0, 1'b0);
        drive(0, 1'b1, 1'b0, 16'h0, 1'b1);
        @(negedge clk);
        check("hold_clr_svalid", svld[0], 1);
        check("hold_clr_sum", get_sum(0), 16);
        tick();
        drive(0, 1'b0, 1'b0, 16'h0, 1'b1);
        @(negedge clk);
        check("hold_clr_hs_svalid", svld[0], 0);
        tick();

        // Reset while holding a sum.
        for (int j = 0; j < 8; j++) cycle(0, 1'b0, 1'b1, 16'd3, 1'b0);
        cycle(0, 1'b0, 1'b0, 16'h0, 1'b0);
        rst_n = 1'b0;
        cycle(0, 1'b0, 1'b0, 16'h0, 1'b0);
        rst_n = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        check("rst_hold_svalid", svld[0], 0);
        check("rst_hold_sum", get_sum(0), 0);
        tick();

        // Streaming 1..8 into ACC_LEN=2.
        seen2.delete();
        n0 = cyc_cnt;
        for (int j = 1; j <= 8; j++) push(2, 16'(j), 1'b1);
        check("stream_cycles", cyc_cnt - n0, SKID ? 8 : 11);
        cycle(2, 1'b0, 1'b0, 16'h0, 1'b1);
        check("stream_nsums", seen2.size(), 4);
        for (int j = 0; j < 4 && j < seen2.size(); j++)
            check($sformatf("stream_sum%0d", j), seen2[j], 4 * j + 3);

        // Downstream stalled: the next batch's closing product must wait.
        k = 1;
        for (int j = 0; j < 6; j++) begin
            drive(2, 1'b0, 1'b1, 16'(k), 1'b0);
            @(negedge clk);
            if (rdy[2]) k++;
            tick();
        end
        check("stall_next", k, SKID ? 4 : 3);
        drive(2, 1'b0, 1'b1, 16'(k), 1'b0);
        @(negedge clk);
        check("stall_ready", rdy[2], 0);
        check("stall_sum", get_sum(2), 3);
        tick();
        for (; k <= 4; k++) push(2, 16'(k), 1'b1);
        cycle(2, 1'b0, 1'b0, 16'h0, 1'b1);
        cycle(2, 1'b0, 1'b0, 16'h0, 1'b1);

        // Random traffic on every instance against the model.
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 500; j++) begin
                logic [15:0] p;
                case ($urandom_range(0, 3))
                    0:       p = 16'h7FFF;
                    1:       p = 16'h8000;
                    2:       p = 16'($urandom_range(0, 7)) - 16'd3;
                    default: p = 16'($urandom);
                endcase
                cycle(i, $urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, p,
                      $urandom_range(0, 2) != 0);
            end
            cycle(i, 1'b1, 1'b0, 16'h0, 1'b1);
            cycle(i, 1'b0, 1'b0, 16'h0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
